// File: rtl/instruction_fetch_unit_if.sv
// Purpose : bundles the fetch stage's decode-side controls, instruction-memory
//           port and IF/ID outputs into one connection.
// Latency : n/a (wires only).
// Backpressure: n/a; stall travels as an ordinary member.
// Ports (slave = fetch unit view):
//   in : stall, redir_valid, redir_type[1:0], id_pc_plus4[31:0], br_imm16[15:0],
//        j_index26[25:0], jr_target[31:0], imem_instr[31:0]
//   out: imem_addr[31:0], ifid_instr[31:0], ifid_pc_plus4[31:0], ifid_valid,
//        pc_fault, fetch_count[31:0]
interface instruction_fetch_unit_if;
  logic        stall;
  logic        redir_valid;
  logic [1:0]  redir_type;
  logic [31:0] id_pc_plus4;
  logic [15:0] br_imm16;
  logic [25:0] j_index26;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        pc_fault;
  logic [31:0] fetch_count;

  modport slave (
    input  stall, redir_valid, redir_type, id_pc_plus4, br_imm16, j_index26,
           jr_target, imem_instr,
    output imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, pc_fault, fetch_count
  );

  modport master (
    output stall, redir_valid, redir_type, id_pc_plus4, br_imm16, j_index26,
           jr_target, imem_instr,
    input  imem_addr, ifid_instr, ifid_pc_plus4, ifid_valid, pc_fault, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Purpose : fetch stage; owns the PC, drives imem address, fills IF/ID, applies
//           decode redirects/stalls, raises a sticky range/alignment fault.
// Latency : imem word at pc appears on ifid_instr one edge later; redirect costs one bubble.
// Backpressure: stall freezes pc, IF/ID and fetch_count; a redirect overrides stall.
// Ports: clk, reset (async, active-high), bus (instruction_fetch_unit_if.slave).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_WORDS = 18
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.slave   bus
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [31:0] r_ifid_pc_plus4, w_ifid_pc_plus4_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic [31:0] r_fetch_count, w_fetch_count_nxt;

  logic [31:0] w_pc_plus4;
  logic        w_fault_hit;
  logic        w_redir_take;
  logic [31:0] w_redir_target;

  assign w_pc_plus4   = r_pc + 32'd4;
  // The range test fires at PC_LIMIT, long before pc+4 could wrap past 2^32.
  assign w_fault_hit  = (r_pc >= PC_LIMIT) || (r_pc[1:0] != 2'b00);
  assign w_redir_take = bus.redir_valid && (bus.redir_type != 2'b11);

  always_comb begin
    w_redir_target = bus.jr_target;
    case (bus.redir_type)
      2'b00:   w_redir_target = bus.id_pc_plus4 + {{14{bus.br_imm16[15]}}, bus.br_imm16, 2'b00};
      2'b01:   w_redir_target = {bus.id_pc_plus4[31:28], bus.j_index26, 2'b00};
      default: w_redir_target = bus.jr_target;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: FAULT is only left through reset.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN && w_fault_hit) w_state_nxt = ST_FAULT;
  end

  // Output/datapath logic, priority: fault > redirect > stall > sequential.
  always_comb begin
    w_pc_nxt            = r_pc;
    w_ifid_instr_nxt    = r_ifid_instr;
    w_ifid_pc_plus4_nxt = r_ifid_pc_plus4;
    w_ifid_valid_nxt    = r_ifid_valid;
    w_fetch_count_nxt   = r_fetch_count;
    if (r_state == ST_FAULT || w_fault_hit) begin
      w_ifid_valid_nxt = 1'b0;
    end else if (w_redir_take) begin
      // Out-of-range or misaligned targets are accepted; the fault comes next edge.
      w_pc_nxt         = w_redir_target;
      w_ifid_valid_nxt = 1'b0;
    end else if (!bus.stall) begin
      w_ifid_instr_nxt    = bus.imem_instr;
      w_ifid_pc_plus4_nxt = w_pc_plus4;
      w_ifid_valid_nxt    = 1'b1;
      w_pc_nxt            = w_pc_plus4;
      w_fetch_count_nxt   = r_fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc            <= RESET_PC;
      r_ifid_instr    <= 32'h0;
      r_ifid_pc_plus4 <= 32'h0;
      r_ifid_valid    <= 1'b0;
      r_fetch_count   <= 32'h0;
    end else begin
      r_pc            <= w_pc_nxt;
      r_ifid_instr    <= w_ifid_instr_nxt;
      r_ifid_pc_plus4 <= w_ifid_pc_plus4_nxt;
      r_ifid_valid    <= w_ifid_valid_nxt;
      r_fetch_count   <= w_fetch_count_nxt;
    end
  end

  assign bus.imem_addr     = r_pc;
  assign bus.ifid_instr    = r_ifid_instr;
  assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
  assign bus.ifid_valid    = r_ifid_valid;
  assign bus.pc_fault      = (r_state == ST_FAULT);
  assign bus.fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Purpose : scoreboard bench for instruction_fetch_unit; directed scenarios then random traffic.
// Latency : expectations are queued before each edge and popped just after it.
// Backpressure: stall is driven randomly like any other decode input.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam int          IMEM_WORDS = 18;
  localparam logic [31:0] LIMIT      = 32'(IMEM_WORDS * 4);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic [31:0] count;
    logic        valid;
    logic        fault;
  } st_t;

  logic clk;
  logic reset;
  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] mem [IMEM_WORDS];
  st_t         model;
  st_t         exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < LIMIT) return mem[a / 4];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_instr = mem_word(bus.imem_addr);

  function automatic st_t reset_state();
    st_t s;
    s = '0;
    s.pc = RESET_PC;
    return s;
  endfunction

  // Architectural reference: what one clock edge does to the fetch state.
  function automatic st_t step(input st_t s, input logic stl, input logic rv,
                               input logic [1:0] rt, input logic [31:0] pp4,
                               input logic [15:0] imm, input logic [25:0] idx,
                               input logic [31:0] jrt);
    st_t n;
    int  off;
    n = s;
    if (s.fault) begin
      n.valid = 1'b0;
    end else if (s.pc >= LIMIT || (s.pc % 4) != 0) begin
      n.fault = 1'b1;
      n.valid = 1'b0;
    end else if (rv && rt != 2'd3) begin
      off = int'($signed(imm)) * 4;
      if (rt == 2'd0)      n.pc = pp4 + 32'(off);
      else if (rt == 2'd1) n.pc = (pp4 & 32'hF000_0000) | (32'(idx) * 4);
      else                 n.pc = jrt;
      n.valid = 1'b0;
    end else if (!stl) begin
      n.instr = mem_word(s.pc);
      n.pp4   = s.pc + 4;
      n.valid = 1'b1;
      n.pc    = s.pc + 4;
      n.count = s.count + 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic stl, input logic rv, input logic [1:0] rt,
                     input logic [31:0] pp4, input logic [15:0] imm,
                     input logic [25:0] idx, input logic [31:0] jrt);
    bus.stall       = stl;
    bus.redir_valid = rv;
    bus.redir_type  = rt;
    bus.id_pc_plus4 = pp4;
    bus.br_imm16    = imm;
    bus.j_index26   = idx;
    bus.jr_target   = jrt;
    model = step(model, stl, rv, rt, pp4, imm, idx, jrt);
    exp_q.push_back(model);
    @(negedge clk);
  endtask

  task automatic free_cyc();
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
  endtask

  // Reset is raised mid-cycle and held across one edge; values are checked asynchronously too.
  task automatic do_reset();
    model = reset_state();
    exp_q.push_back(model);
    reset = 1'b1;
    #1;
    chk("async_rst_pc", bus.imem_addr, RESET_PC);
    chk("async_rst_valid", 32'(bus.ifid_valid), 32'd0);
    chk("async_rst_fault", 32'(bus.pc_fault), 32'd0);
    chk("async_rst_count", bus.fetch_count, 32'd0);
    chk("async_rst_instr", bus.ifid_instr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops one expectation per edge and compares against the outputs.
  initial begin
    st_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.imem_addr, e.pc);
        chk("sb_valid", 32'(bus.ifid_valid), 32'(e.valid));
        chk("sb_fault", 32'(bus.pc_fault), 32'(e.fault));
        chk("sb_count", bus.fetch_count, e.count);
        if (e.valid) begin
          chk("sb_instr", bus.ifid_instr, e.instr);
          chk("sb_pp4", bus.ifid_pc_plus4, e.pp4);
        end
      end
    end
  end

  initial begin
    logic        s, rv;
    logic [1:0]  rt;
    logic [31:0] pp4, jrt;
    logic [15:0] imm;
    logic [25:0] idx;
    for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
    reset = 1'b0;
    bus.stall = 1'b0; bus.redir_valid = 1'b0; bus.redir_type = 2'd0;
    bus.id_pc_plus4 = 32'h0; bus.br_imm16 = 16'h0; bus.j_index26 = 26'h0; bus.jr_target = 32'h0;
    #2;

    // Three sequential fetches.
    do_reset();
    repeat (3) free_cyc();
    chk("seq_instr", bus.ifid_instr, mem[2]);
    chk("seq_pp4", bus.ifid_pc_plus4, 32'd12);
    chk("seq_count", bus.fetch_count, 32'd3);
    chk("seq_valid", 32'(bus.ifid_valid), 32'd1);

    // Stall holds pc and IF/ID.
    do_reset();
    free_cyc();
    repeat (2) cyc(1'b1, 1'b0, 2'd0, 32'h0, 16'h0, 26'h0, 32'h0);
    chk("stall_pc", bus.imem_addr, 32'd4);
    chk("stall_instr", bus.ifid_instr, mem[0]);
    chk("stall_count", bus.fetch_count, 32'd1);
    free_cyc();
    chk("stall_release", bus.ifid_instr, mem[1]);

    // Branch with -1 word offset from id_pc_plus4=8 lands at 4.
    cyc(1'b0, 1'b1, 2'd0, 32'd8, 16'hFFFF, 26'h0, 32'h0);
    chk("br_pc", bus.imem_addr, 32'd4);
    chk("br_bubble", 32'(bus.ifid_valid), 32'd0);
    free_cyc();
    chk("br_word", bus.ifid_instr, mem[1]);

    // Jump with simultaneous stall: redirect wins.
    cyc(1'b1, 1'b1, 2'd1, 32'd4, 16'h0, 26'h8, 32'h0);
    chk("j_pc", bus.imem_addr, 32'h20);
    chk("j_bubble", 32'(bus.ifid_valid), 32'd0);
    free_cyc();
    chk("j_word", bus.ifid_instr, mem[8]);
    chk("j_pp4", bus.ifid_pc_plus4, 32'h24);

    // Misaligned jr: accepted, fault one edge later, then redirects ignored.
    cyc(1'b0, 1'b1, 2'd2, 32'h0, 16'h0, 26'h0, 32'h6);
    chk("jr_pc", bus.imem_addr, 32'h6);
    chk("jr_nofault_yet", 32'(bus.pc_fault), 32'd0);
    free_cyc();
    chk("jr_fault", 32'(bus.pc_fault), 32'd1);
    chk("jr_fault_valid", 32'(bus.ifid_valid), 32'd0);
    cyc(1'b0, 1'b1, 2'd1, 32'd0, 16'h0, 26'h1, 32'h0);
    chk("fault_redir_ignored", bus.imem_addr, 32'h6);
    do_reset();
    chk("fault_cleared", 32'(bus.pc_fault), 32'd0);

    // Run off the end of instruction memory.
    repeat (IMEM_WORDS) free_cyc();
    chk("end_last_word", bus.ifid_instr, mem[IMEM_WORDS-1]);
    chk("end_pc", bus.imem_addr, LIMIT);
    free_cyc();
    chk("end_fault", 32'(bus.pc_fault), 32'd1);
    chk("end_pc_frozen", bus.imem_addr, LIMIT);
    chk("end_count", bus.fetch_count, 32'(IMEM_WORDS));

    // Random traffic, with occasional resets (including mid-stall/redirect).
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 3) begin
        do_reset();
      end else begin
        s   = ($urandom_range(0, 3) == 0);
        rv  = ($urandom_range(0, 4) == 0);
        rt  = 2'($urandom_range(0, 3));
        pp4 = ($urandom_range(0, 19) == 0) ? $urandom : 32'(4 * $urandom_range(0, IMEM_WORDS));
        imm = 16'($urandom_range(0, 8)) - 16'd4;
        idx = 26'($urandom_range(0, IMEM_WORDS));
        jrt = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 200))
                                          : 32'(4 * $urandom_range(0, IMEM_WORDS - 1));
        cyc(s, rv, rt, pp4, imm, idx, jrt);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
